alu_core: RTL and testbench
===========================

# alu_core

Combinational WIDTH-bit integer ALU with ADD, SUB, AND and OR operations and NZCV condition flags. It serves as the datapath execution unit: operands in, result and flags out in the same cycle. An optional clocked status register latches the flags for later conditional logic.

## Interface
- WIDTH, default 32: operand/result width in bits (≥2).
- clk  input  1  clock; used only by the status register.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- control  input  2  operation select. Encodings from the shared ALU header: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11.
- flags_we  input  1  status register write enable.
- result  output  WIDTH  operation result, combinational.
- flags  output  4  {N,Z,C,V}, combinational. Header masks: ALU_FLAG_NEG=4'b1000, ALU_FLAG_ZERO=4'b0100, ALU_FLAG_CARRY=4'b0010, ALU_FLAG_OFLOW=4'b0001.
- flags_q  output  4  registered {N,Z,C,V} from the status register.

## Operation
- ADD: result = (a + b) mod 2^WIDTH.
- SUB: result = (a − b) mod 2^WIDTH, computed as a + ~b + 1.
- AND: result = a & b.
- OR: result = a | b.
- N = result[WIDTH−1] for all operations.
- Z = (result == 0) for all operations.
- C, ADD: carry out of bit WIDTH−1, i.e. the unsigned a + b > 2^WIDTH − 1.
- C, SUB: borrow, i.e. unsigned a < b. This is the inverse of the adder carry-out.
- C, AND/OR: 0.
- V, ADD: a[MSB] == b[MSB] and result[MSB] != a[MSB].
- V, SUB: a[MSB] != b[MSB] and result[MSB] != a[MSB].
- V, AND/OR: 0.
- All four control codes are defined, so there is no illegal-opcode case. Outputs never go X for known inputs.
- Implement with a single shared WIDTH+1-bit adder for ADD/SUB.

## Timing
- result and flags are purely combinational, with zero-cycle latency. They are valid within the same cycle, before the next clk edge.
- flags_q is updated at posedge clk when flags_we=1, loading the current flags. It holds its value when flags_we=0.
- On rst=1, flags_q becomes 4'b0000 immediately (asynchronous) and stays there while rst is high. rst has no effect on result/flags.
- If rst deasserts in the same cycle that flags_we=1, the first load happens at the first posedge after deassertion.

## Configuration
- ALU_FLAG_REG_EN defined: the status register is built as described in Timing.
- ALU_FLAG_REG_EN undefined: no flops are built, flags_q is tied to 4'b0000, and clk, rst and flags_we are unused. result/flags behaviour is identical in both cases.

## Test plan
- ADD, a=32'hFFFF_FFFF, b=32'h0000_0001 -> result=0, flags=4'b0110 (Z, C).
- ADD, a=32'h7FFF_FFFF, b=32'h0000_0001 -> result=32'h8000_0000, flags=4'b1001 (N, V).
- SUB, a=32'h0000_0001, b=32'h0000_0002 -> result=32'hFFFF_FFFF, flags=4'b1010 (N, C/borrow). SUB, a=32'h8000_0000, b=1 -> result=32'h7FFF_FFFF, flags=4'b0001.
- AND, a=32'hF0F0_F0F0, b=32'h0F0F_0F0F -> result=0, flags=4'b0100. OR on the same operands -> result=32'hFFFF_FFFF, flags=4'b1000.
- Status register (with ALU_FLAG_REG_EN):
  - rst pulse -> flags_q=0 without any clk edge.
  - Zero-result ADD with flags_we=1 -> flags_q=4'b0110 after the posedge.
  - flags_we=0 with new operands -> flags_q unchanged.
  - rst asserted mid-run -> flags_q=0 immediately.
- Random regression: 1000 cycles of random a, b and control, comparing against a WIDTH+1-bit reference model for result, N, Z, C and V.

Source files
------------

// File: rtl/alu_core.sv
// alu_core: WIDTH-bit integer ALU (ADD, SUB, AND, OR) with {N,Z,C,V} flags.
// result and flags are purely combinational. ADD and SUB share one WIDTH+1-bit adder.
// Optional status register, enabled by defining ALU_FLAG_REG_EN: flags_q captures
// the flags on posedge clk while flags_we=1. rst clears it asynchronously.
// When ALU_FLAG_REG_EN is undefined, no flops are built and flags_q is tied to 0.
module alu_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       control,
    input  logic             flags_we,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [3:0]       flags_q
);

    // Operation encodings shared with the rest of the datapath
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // Flag bit masks within {N,Z,C,V}
    localparam logic [3:0] ALU_FLAG_NEG   = 4'b1000;
    localparam logic [3:0] ALU_FLAG_ZERO  = 4'b0100;
    localparam logic [3:0] ALU_FLAG_CARRY = 4'b0010;
    localparam logic [3:0] ALU_FLAG_OFLOW = 4'b0001;

    localparam int MSB = WIDTH - 1;

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic             carry_out;
    logic [WIDTH-1:0] and_bits;
    logic [WIDTH-1:0] or_bits;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;

    // SUB reuses the adder: a + ~b + 1. The +1 enters as the carry-in.
    assign is_sub    = (control == ALU_SUB);
    assign b_eff     = is_sub ? ~b : b;
    assign sum_ext   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    assign carry_out = sum_ext[WIDTH];

    // Bitwise logic operations, one slice per bit
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_logic
            assign and_bits[gi] = a[gi] & b[gi];
            assign or_bits[gi]  = a[gi] | b[gi];
        end
    endgenerate

    // Result select. All four codes are defined, so there is no default hole.
    always_comb begin
        result = sum_ext[WIDTH-1:0];
        case (control)
            ALU_ADD: result = sum_ext[WIDTH-1:0];
            ALU_SUB: result = sum_ext[WIDTH-1:0];
            ALU_AND: result = and_bits;
            ALU_OR:  result = or_bits;
            default: result = sum_ext[WIDTH-1:0];
        endcase
    end

    // Condition flags. For SUB, C is a borrow, so it is the inverted adder carry.
    always_comb begin
        flag_n = result[MSB];
        flag_z = (result == '0);
        flag_c = 1'b0;
        flag_v = 1'b0;
        case (control)
            ALU_ADD: begin
                flag_c = carry_out;
                flag_v = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                flag_c = ~carry_out;
                flag_v = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
            end
            default: begin
                flag_c = 1'b0;
                flag_v = 1'b0;
            end
        endcase
    end

    assign flags = (flag_n ? ALU_FLAG_NEG   : 4'b0000)
                 | (flag_z ? ALU_FLAG_ZERO  : 4'b0000)
                 | (flag_c ? ALU_FLAG_CARRY : 4'b0000)
                 | (flag_v ? ALU_FLAG_OFLOW : 4'b0000);

`ifdef ALU_FLAG_REG_EN
    logic [3:0] flags_q_reg;

    // Status register: asynchronous clear, loads the live flags when enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q_reg <= 4'b0000;
        end else if (flags_we) begin
            flags_q_reg <= flags;
        end
    end

    assign flags_q = flags_q_reg;
`else
    // No status register in this build. The clock, reset and write enable are left unconnected.
    logic unused_status_inputs;
    assign unused_status_inputs = ^{clk, rst, flags_we};
    assign flags_q = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core. Expected results are pushed to a scoreboard
// when stimulus is driven and popped when the combinational output settles.
// Status-register expectations follow the ALU_FLAG_REG_EN build option.
module tb_alu_core;

    localparam int W = 32;

`ifdef ALU_FLAG_REG_EN
    localparam bit REG_EN = 1'b1;
`else
    localparam bit REG_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   control;
    logic         flags_we;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic [3:0]   flags_q;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flg;
    } exp_t;

    exp_t sb[$];

    alu_core #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .control  (control),
        .flags_we (flags_we),
        .result   (result),
        .flags    (flags),
        .flags_q  (flags_q)
    );

    always #5 clk = ~clk;

    // Reference model. It widens the operands and uses signed arithmetic to detect overflow.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        logic [W:0]  wide;
        longint      sref;
        logic        c;
        logic        v;
        wide = '0;
        sref = 0;
        c    = 1'b0;
        case (op)
            2'b00: begin
                wide = {1'b0, x} + {1'b0, y};
                c    = wide[W];
                sref = longint'($signed(x)) + longint'($signed(y));
            end
            2'b01: begin
                wide = {1'b0, x} - {1'b0, y};
                c    = (x < y);
                sref = longint'($signed(x)) - longint'($signed(y));
            end
            2'b10: wide = {1'b0, x & y};
            default: wide = {1'b0, x | y};
        endcase
        e.res = wide[W-1:0];
        v = (op == 2'b00 || op == 2'b01) && (sref != longint'($signed(e.res)));
        e.flg = {e.res[W-1], (e.res == '0), c, v};
        return e;
    endfunction

    // Drive one operation, push its expectation, let it settle, then pop and compare
    task automatic run_op(input string nm, input logic [1:0] op, input logic [W-1:0] x,
                          input logic [W-1:0] y, input exp_t e);
        exp_t got;
        @(negedge clk);
        a = x;
        b = y;
        control = op;
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        checks++;
        if (result !== got.res) begin
            failures++;
            $display("FAIL %s result: got %h want %h", nm, result, got.res);
        end
        checks++;
        if (flags !== got.flg) begin
            failures++;
            $display("FAIL %s flags: got %b want %b", nm, flags, got.flg);
        end
        $display("txn %s op=%0d a=%h b=%h result=%h flags=%b", nm, op, x, y, result, flags);
    endtask

    function automatic exp_t mk(input logic [W-1:0] r, input logic [3:0] f);
        exp_t e;
        e.res = r;
        e.flg = f;
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        flags_we = 1'b0;
        a = '0;
        b = '0;
        control = 2'b00;
        #1;
        checks++;
        if (flags_q !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags_q: got %b want 0000", flags_q);
        end
        checks++;
        if (flags !== 4'b0100) begin
            failures++;
            $display("FAIL reset_flags_comb: got %b want 0100", flags);
        end
        $display("txn reset flags_q=%b flags=%b", flags_q, flags);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op("add_carry_zero", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, mk(32'h0000_0000, 4'b0110));
        run_op("add_overflow",   2'b00, 32'h7FFF_FFFF, 32'h0000_0001, mk(32'h8000_0000, 4'b1001));
        run_op("sub_borrow",     2'b01, 32'h0000_0001, 32'h0000_0002, mk(32'hFFFF_FFFF, 4'b1010));
        run_op("sub_overflow",   2'b01, 32'h8000_0000, 32'h0000_0001, mk(32'h7FFF_FFFF, 4'b0001));
        run_op("and_zero",       2'b10, 32'hF0F0_F0F0, 32'h0F0F_0F0F, mk(32'h0000_0000, 4'b0100));
        run_op("or_ones",        2'b11, 32'hF0F0_F0F0, 32'h0F0F_0F0F, mk(32'hFFFF_FFFF, 4'b1000));
        run_op("sub_equal",      2'b01, 32'h1234_5678, 32'h1234_5678, mk(32'h0000_0000, 4'b0100));
        run_op("add_plain",      2'b00, 32'h0000_0003, 32'h0000_0004, mk(32'h0000_0007, 4'b0000));
    endtask

    task automatic check_fq(input string nm, input logic [3:0] want_when_en);
        logic [3:0] want;
        want = REG_EN ? want_when_en : 4'b0000;
        checks++;
        if (flags_q !== want) begin
            failures++;
            $display("FAIL %s: flags_q got %b want %b", nm, flags_q, want);
        end
        $display("txn %s flags_q=%b", nm, flags_q);
    endtask

    task automatic test_status_reg();
        // Load from a zero-result ADD
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'h1; control = 2'b00; flags_we = 1'b1;
        @(posedge clk); #1;
        check_fq("sr_load", 4'b0110);
        // Hold while write enable is low
        @(negedge clk);
        flags_we = 1'b0; a = 32'h7FFF_FFFF; b = 32'h1;
        @(posedge clk); #1;
        check_fq("sr_hold", 4'b0110);
        // Asynchronous clear between clock edges
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_fq("sr_async_clear", 4'b0000);
        // Reset held through an enabled edge keeps the register clear
        flags_we = 1'b1; a = 32'h1; b = 32'h2; control = 2'b01;
        @(posedge clk); #1;
        check_fq("sr_rst_held", 4'b0000);
        // Release reset with the enable already high. The first load happens on the next edge.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_fq("sr_release", 4'b0000);
        @(posedge clk); #1;
        check_fq("sr_first_load", 4'b1010);
        @(negedge clk);
        flags_we = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;
        for (int i = 0; i < 1000; i++) begin
            op = 2'($urandom_range(0, 3));
            x  = $urandom;
            y  = $urandom;
            if (i % 10 == 0) y = x;
            if (i % 17 == 0) x = 32'h8000_0000;
            run_op("rand", op, x, y, model(op, x, y));
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_status_reg();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
